// File: rtl/tile_playfield.sv
// tile_playfield: scrolling 4-lane Piano Tiles playfield with press judging and scoring
module tile_playfield #(
    parameter int ROWS          = 8,
    parameter int SCROLL_PERIOD = 12_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        tiles,
    input  logic [3:0]        buttons,
    input  logic              start,
    output logic [4*ROWS-1:0] field,
    output logic [7:0]        score,
    output logic              game_over,
    output logic              scroll,
    output logic              hit
);
    localparam int CW = $clog2(SCROLL_PERIOD);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] LAST = CW'(SCROLL_PERIOD - 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4*ROWS-1:0] field_q, field_d, f;
    logic [7:0]        score_q, score_d;
    logic              go_q, go_d, scroll_q, scroll_d, hit_q, hit_d;
    logic [3:0]        btn_prev_q, edges, norm;
    logic [RW-1:0]     tgt;
    logic              found, miss;

    assign field     = field_q;
    assign score     = score_q;
    assign game_over = go_q;
    assign scroll    = scroll_q;
    assign hit       = hit_q;
    assign edges     = buttons & ~btn_prev_q;
    assign norm      = tiles & (~tiles + 4'd1);

    // locate the lowest nonzero row, which is the only row a press may clear
    always_comb begin
        found = 1'b0;
        tgt   = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (field_q[4*r +: 4] != 4'b0) begin
                found = 1'b1;
                tgt   = RW'(r);
            end
        end
    end

    // game FSM: press resolves on the pre-scroll field, then the scroll sees the result
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        field_d  = field_q;
        score_d  = score_q;
        go_d     = go_q;
        scroll_d = 1'b0;
        hit_d    = 1'b0;
        miss     = 1'b0;
        f        = field_q;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    field_d = '0;
                    score_d = '0;
                    go_d    = 1'b0;
                end
            end
            RUN: begin
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
                if (edges != 4'b0 && found) begin
                    if (edges == field_q[4*tgt +: 4]) begin
                        f[4*tgt +: 4] = 4'b0;
                        score_d       = (score_q == 8'hff) ? score_q : score_q + 8'd1;
                        hit_d         = 1'b1;
                    end else begin
                        miss = 1'b1;
                    end
                end
                if (!miss && cnt_q == LAST) begin
                    if (f[3:0] != 4'b0) begin
                        miss = 1'b1;
                    end else begin
                        f        = {norm, f[4*ROWS-1:4]};
                        scroll_d = 1'b1;
                    end
                end
                if (miss) begin
                    state_d = OVER;
                    go_d    = 1'b1;
                    cnt_d   = cnt_q;
                    score_d = score_q;
                    hit_d   = 1'b0;
                end else begin
                    field_d = f;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; button history is tracked in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            field_q    <= '0;
            score_q    <= '0;
            go_q       <= 1'b0;
            scroll_q   <= 1'b0;
            hit_q      <= 1'b0;
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            field_q    <= field_d;
            score_q    <= score_d;
            go_q       <= go_d;
            scroll_q   <= scroll_d;
            hit_q      <= hit_d;
            btn_prev_q <= buttons;
        end
    end
endmodule

// File: tb/tb_tile_playfield.sv
// tb_tile_playfield: directed scoreboard bench for tile_playfield (ROWS=4, SCROLL_PERIOD=4)
module tb_tile_playfield;
    typedef struct packed {
        logic [15:0] f;
        logic [7:0]  s;
        logic        go;
        logic        sc;
        logic        h;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  tiles = 4'b0;
    logic [3:0]  buttons = 4'b0;
    logic        start = 1'b0;
    logic        probe = 1'b0;
    logic [15:0] field;
    logic [7:0]  score;
    logic        game_over, scroll, hit;
    logic        go_prev = 1'b0;
    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;

    tile_playfield #(.ROWS(4), .SCROLL_PERIOD(4)) dut (
        .clk(clk), .rst(rst), .tiles(tiles), .buttons(buttons), .start(start),
        .field(field), .score(score), .game_over(game_over), .scroll(scroll), .hit(hit)
    );

    always #5 clk = ~clk;

    // monitor: every output event (scroll, hit, game_over rise, probe) consumes one expectation
    always @(negedge clk) begin
        if (scroll || hit || (game_over && !go_prev) || probe) begin
            exp_t e;
            exp_t a;
            a = '{f: field, s: score, go: game_over, sc: scroll, h: hit};
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event vec%0d got f=%h s=%0d go=%b sc=%b h=%b", vectors, a.f, a.s, a.go, a.sc, a.h);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d got f=%h s=%0d go=%b sc=%b h=%b exp f=%h s=%0d go=%b sc=%b h=%b",
                             vectors, a.f, a.s, a.go, a.sc, a.h, e.f, e.s, e.go, e.sc, e.h);
                end
            end
        end
        go_prev <= game_over;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] f, input logic [7:0] s, input logic go, input logic sc, input logic h);
        q.push_back('{f: f, s: s, go: go, sc: sc, h: h});
    endtask

    task automatic check_now(input logic [15:0] f, input logic [7:0] s, input logic go);
        push(f, s, go, 1'b0, 1'b0);
        probe = 1'b1;
        cyc(1);
        probe = 1'b0;
    endtask

    task automatic restart_lane2();
        buttons = 4'b0;
        tiles   = 4'b0100;
        start   = 1'b1;
        cyc(1);
        start = 1'b0;
        check_now(16'h0000, 8'd0, 1'b0);
        push(16'h4000, 8'd0, 1'b0, 1'b1, 1'b0);
        push(16'h0400, 8'd0, 1'b0, 1'b1, 1'b0);
        push(16'h0040, 8'd0, 1'b0, 1'b1, 1'b0);
        push(16'h0004, 8'd0, 1'b0, 1'b1, 1'b0);
        cyc(3);
        tiles = 4'b0;
        cyc(12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        cyc(3);
        rst = 1'b0;
        check_now(16'h0000, 8'd0, 1'b0);
        tiles = 4'b1111;
        cyc(20);
        check_now(16'h0000, 8'd0, 1'b0);
        tiles = 4'b0110;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        push(16'h2000, 8'd0, 1'b0, 1'b1, 1'b0);
        cyc(4);
        tiles = 4'b0000;
        push(16'h0200, 8'd0, 1'b0, 1'b1, 1'b0);
        cyc(4);
        tiles = 4'b1100;
        push(16'h4020, 8'd0, 1'b0, 1'b1, 1'b0);
        cyc(4);
        tiles = 4'b0000;
        push(16'h0402, 8'd0, 1'b0, 1'b1, 1'b0);
        cyc(4);
        buttons = 4'b0010;
        push(16'h0400, 8'd1, 1'b0, 1'b0, 1'b1);
        cyc(2);
        buttons = 4'b0000;
        push(16'h0040, 8'd1, 1'b0, 1'b1, 1'b0);
        cyc(2);
        push(16'h0004, 8'd1, 1'b0, 1'b1, 1'b0);
        cyc(7);
        buttons = 4'b0100;
        tiles   = 4'b1000;
        push(16'h8000, 8'd2, 1'b0, 1'b1, 1'b1);
        cyc(1);
        buttons = 4'b0000;
        tiles   = 4'b0000;
        push(16'h0800, 8'd2, 1'b0, 1'b1, 1'b0);
        push(16'h0080, 8'd2, 1'b0, 1'b1, 1'b0);
        push(16'h0008, 8'd2, 1'b0, 1'b1, 1'b0);
        push(16'h0008, 8'd2, 1'b1, 1'b0, 1'b0);
        cyc(16);
        buttons = 4'b1000;
        cyc(8);
        buttons = 4'b0000;
        check_now(16'h0008, 8'd2, 1'b1);
        restart_lane2();
        buttons = 4'b0001;
        push(16'h0004, 8'd0, 1'b1, 1'b0, 1'b0);
        cyc(1);
        buttons = 4'b0000;
        cyc(6);
        check_now(16'h0004, 8'd0, 1'b1);
        restart_lane2();
        buttons = 4'b0101;
        push(16'h0004, 8'd0, 1'b1, 1'b0, 1'b0);
        cyc(1);
        buttons = 4'b0000;
        cyc(6);
        check_now(16'h0004, 8'd0, 1'b1);
        tiles = 4'b0001;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        push(16'h1000, 8'd0, 1'b0, 1'b1, 1'b0);
        cyc(7);
        for (int k = 1; k <= 256; k++) begin
            buttons = 4'b0001;
            push(16'h1000, (k > 255) ? 8'd255 : 8'(k), 1'b0, 1'b1, 1'b1);
            cyc(1);
            buttons = 4'b0000;
            if (k == 10) begin
                start = 1'b1;
                cyc(1);
                start = 1'b0;
                cyc(2);
            end else begin
                cyc(3);
            end
        end
        push(16'h1100, 8'd255, 1'b0, 1'b1, 1'b0);
        push(16'h1110, 8'd255, 1'b0, 1'b1, 1'b0);
        push(16'h1111, 8'd255, 1'b0, 1'b1, 1'b0);
        push(16'h1111, 8'd255, 1'b1, 1'b0, 1'b0);
        cyc(13);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check_now(16'h0000, 8'd0, 1'b0);
        push(16'h1000, 8'd0, 1'b0, 1'b1, 1'b0);
        cyc(4);
        rst = 1'b1;
        check_now(16'h0000, 8'd0, 1'b0);
        rst = 1'b0;
        cyc(6);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event exp f=%h s=%0d go=%b sc=%b h=%b never seen", e.f, e.s, e.go, e.sc, e.h);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
